// File: rtl/sipo_loader.sv
// rtl/sipo_loader.sv - framed MSB-first serial-to-parallel word assembler with load strobe
//
// Ports:
//   CLK      system clock, all state changes on the rising edge
//   RST      synchronous active-low reset
//   SIN      serial data bit, sampled when SVALID=1 and FRAME=1
//   SVALID   SIN carries a valid bit this cycle
//   FRAME    high for the duration of a word transfer
//   CLR_ERR  clears the sticky ERR flag
//   DOUT     last completed word (drives downstream register DATA)
//   LOAD     one-cycle strobe when DOUT updates (drives register ENA)
//   BIT_CNT  bits accepted in the current word, 0..WIDTH-1
//   ERR      sticky flag: a partial word was aborted by FRAME dropping

module sipo_loader #(
    parameter int WIDTH = 8,
    parameter int CW    = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             SIN,
    input  logic             SVALID,
    input  logic             FRAME,
    input  logic             CLR_ERR,
    output logic [WIDTH-1:0] DOUT,
    output logic             LOAD,
    output logic [CW-1:0]    BIT_CNT,
    output logic             ERR
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sr;

    wire              accept  = FRAME && SVALID;
    wire [WIDTH-1:0]  sr_next = {sr[WIDTH-2:0], SIN};

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state   <= IDLE;
            sr      <= '0;
            DOUT    <= '0;
            LOAD    <= 1'b0;
            BIT_CNT <= '0;
            ERR     <= 1'b0;
        end else begin
            LOAD <= 1'b0;
            // Clear first so an abort on the same edge overrides it.
            if (CLR_ERR) begin
                ERR <= 1'b0;
            end
            case (state)
                IDLE: begin
                    // FRAME low or no valid bit while idle is not an error.
                    if (accept) begin
                        sr      <= sr_next;
                        BIT_CNT <= CW'(1);
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (!FRAME) begin
                        // Partial word aborted: drop it, keep DOUT.
                        BIT_CNT <= '0;
                        state   <= IDLE;
                        ERR     <= 1'b1;
                    end else if (SVALID) begin
                        if (BIT_CNT == CW'(WIDTH - 1)) begin
                            // Last bit: publish the word; a bit arriving next
                            // cycle already starts the following word.
                            sr      <= sr_next;
                            DOUT    <= sr_next;
                            LOAD    <= 1'b1;
                            BIT_CNT <= '0;
                            state   <= IDLE;
                        end else begin
                            sr      <= sr_next;
                            BIT_CNT <= BIT_CNT + CW'(1);
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    BIT_CNT <= '0;
                end
            endcase
        end
    end

endmodule
